// File: rtl/switch_debouncer.sv
// Debounces one mechanical switch: a two-flop synchronizer, then a stability counter
// that accepts a new level after DEBOUNCE_CYCLES consecutive mismatching cycles.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  output logic                 out,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] toggle_cnt
);

  localparam int SW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] LAST = SW'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

  // Counter value 0 is the idle state; any nonzero value means a new level is qualifying.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    tcnt_d = tcnt_q;
    if (sync2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      out_d  = sync2_q;
      cnt_d  = '0;
      tcnt_d = tcnt_q + CNT_WIDTH'(1);
      rise_d = sync2_q;
      fall_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign out        = out_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign toggle_cnt = tcnt_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: vector table, hand-written corner sequences and
// random runs checked against a sliding-window reference model.
module tb_switch_debouncer;
  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_r;
  logic         out, rise, fall;
  logic [W-1:0] toggle_cnt;

  always #5 clk = ~clk;

  switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_r), .out(out),
    .rise(rise), .fall(fall), .toggle_cnt(toggle_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: hist[k-1] is the raw input sampled at edge k since reset. The
  // synchronized level seen at edge m is the input from edge m-2 (0 before that).
  // A new level is accepted at edge n when the previous D edges all saw a level
  // different from out and none of those edges lies at or before the last acceptance.
  logic         hist[$];
  int           n, last_acc;
  logic         m_out, m_rise, m_fall;
  logic [W-1:0] m_cnt;

  typedef struct {
    logic         in_v;
    logic         e_out;
    logic         e_rise;
    logic         e_fall;
    logic [W-1:0] e_cnt;
  } vec_t;
  vec_t tv[16];

  function automatic logic s_at(int m);
    if (m < 3) return 1'b0;
    return hist[m-3];
  endfunction

  task automatic model_reset();
    hist.delete();
    n = 0; last_acc = 0;
    m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_cnt = '0;
  endtask

  task automatic model_edge(input logic v);
    bit acc;
    hist.push_back(v);
    n++;
    m_rise = 1'b0; m_fall = 1'b0;
    acc = (n - last_acc >= D);
    for (int m = n - D + 1; m <= n; m++)
      if (m < 1 || s_at(m) == m_out) acc = 1'b0;
    if (acc) begin
      m_out = ~m_out;
      m_rise = m_out;
      m_fall = ~m_out;
      m_cnt++;
      last_acc = n;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v);
    in_r = v;
    @(posedge clk);
    model_edge(v);
    #1;
    chk("out", 32'(out), 32'(m_out));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("toggle_cnt", 32'(toggle_cnt), 32'(m_cnt));
    chk("rise_and_fall", 32'(rise & fall), 32'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_r = 1'b0;
    #1;
    model_reset();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cnt", 32'(toggle_cnt), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic lvl;
    int   len;

    for (int i = 0; i < 8; i++) begin
      tv[i].in_v     = 1'b1;
      tv[i].e_out    = (i >= 5);
      tv[i].e_rise   = (i == 5);
      tv[i].e_fall   = 1'b0;
      tv[i].e_cnt    = (i >= 5) ? 8'd1 : 8'd0;
      tv[8+i].in_v   = 1'b0;
      tv[8+i].e_out  = (i < 5);
      tv[8+i].e_rise = 1'b0;
      tv[8+i].e_fall = (i == 5);
      tv[8+i].e_cnt  = (i >= 5) ? 8'd2 : 8'd1;
    end

    in_r = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_rise", 32'(rise), 32'd0);
    chk("reset_fall", 32'(fall), 32'd0);
    chk("reset_cnt", 32'(toggle_cnt), 32'd0);
    #4 rst_n = 1'b1;

    // Idle with input low.
    repeat (20) cyc(1'b0);

    // Clean rise then clean fall, edge-by-edge expectations.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(tv[i].in_v);
      chk($sformatf("tv%0d_out", i), 32'(out), 32'(tv[i].e_out));
      chk($sformatf("tv%0d_rise", i), 32'(rise), 32'(tv[i].e_rise));
      chk($sformatf("tv%0d_fall", i), 32'(fall), 32'(tv[i].e_fall));
      chk($sformatf("tv%0d_cnt", i), 32'(toggle_cnt), 32'(tv[i].e_cnt));
    end

    // Short pulse and bouncing pulse must both be rejected.
    do_reset();
    repeat (4) cyc(1'b0);
    repeat (3) cyc(1'b1);
    repeat (6) cyc(1'b0);
    chk("short_pulse_out", 32'(out), 32'd0);
    chk("short_pulse_cnt", 32'(toggle_cnt), 32'd0);
    foreach (hist[i]) ; // no-op keeps hist referenced only via model
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    repeat (6) cyc(1'b0);
    chk("bounce_out", 32'(out), 32'd0);
    chk("bounce_cnt", 32'(toggle_cnt), 32'd0);

    // Counter wrap after 256 accepted transitions.
    do_reset();
    lvl = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      lvl = ~lvl;
      repeat (6) cyc(lvl);
      if (i == 256) chk("wrap_256", 32'(toggle_cnt), 32'd0);
      if (i == 257) chk("wrap_257", 32'(toggle_cnt), 32'd1);
    end

    // Reset between edges while a 1->0 qualification is at count 2.
    do_reset();
    repeat (6) cyc(1'b1);
    repeat (4) cyc(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midq_out", 32'(out), 32'd0);
    chk("midq_rise", 32'(rise), 32'd0);
    chk("midq_fall", 32'(fall), 32'd0);
    chk("midq_cnt", 32'(toggle_cnt), 32'd0);
    in_r = 1'b1;
    model_reset();
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1);
      if (k == 5) chk("post_rst_out_e5", 32'(out), 32'd0);
      if (k == 6) chk("post_rst_rise_e6", 32'(rise), 32'd1);
    end
    chk("post_rst_cnt", 32'(toggle_cnt), 32'd1);

    // Random runs of varying length.
    do_reset();
    for (int r = 0; r < 300; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      repeat (len) cyc(lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
